mem_master_8to32: RTL and testbench
===================================

# mem_master_8to32

- Initiator side of the byte-wide synchronous memory request interface.
- Accepts one 32-bit load/store from the core's load/store stage and breaks it into 1, 2 or 4 sequential byte transactions toward the on-chip memory.
- Assembles little-endian read data and sign- or zero-extends it.
- Signals completion with a single-cycle done pulse.

## Interface
- ADDR_WIDTH, 13, memory address width; byte addresses wrap modulo 2^ADDR_WIDTH
- i_clk  in  1  clock; one clock domain
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  start strobe; sampled only in IDLE
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- i_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- i_addr  in  32  byte address
- i_wdata  in  32  store data; byte k = bits [8k+7:8k]
- o_rdata  out  32  load result; valid while o_done is high, held until the next accept
- o_done  out  1  one-cycle completion pulse
- o_busy  out  1  high from accept through DONE
- o_error  out  1  misalignment flag, qualified by o_done
- o_mem_request  out  1  one-cycle request pulse per byte
- o_mem_write  out  1  write qualifier for o_mem_request
- o_mem_address  out  ADDR_WIDTH  byte address
- o_mem_data  out  8  write byte
- i_mem_data  in  8  read byte
- i_mem_data_DV  in  1  responder acknowledge; read byte is valid in the same cycle

## Operation
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - When i_req=1, capture the operands, set byte count N (1/2/4) and index k=0, then go to REQ.
  - i_req is ignored in every other state.
- **REQ:**
  - Drive o_mem_request=1, o_mem_write=i_we, o_mem_address=(addr+k) truncated to ADDR_WIDTH, o_mem_data=wdata byte k.
  - Go to WAIT.
- **WAIT:**
  - o_mem_request=0. Address, write and data outputs are held.
  - On i_mem_data_DV, store i_mem_data into rdata byte k.
  - If k=N-1, go to DONE; otherwise increment k and go to REQ.
  - Without DV, stay in WAIT. There is no timeout.
- **DONE:**
  - o_done=1 and o_rdata is final. Go to IDLE.
  - For a load, bytes above N are the sign of byte N-1 or zero, per i_unsigned.
  - For a store, o_rdata=0.
- **Ignored DV:** i_mem_data_DV is ignored outside WAIT, including a stale acknowledge after reset.
- **Addressing:** little-endian. Address increments wrap, e.g. 0x1FFF+1 → 0x0000 at ADDR_WIDTH=13.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Reset is asynchronous and mid-transaction abort is allowed; the aborted partial store is not rolled back.
- **Per byte:** 2 cycles (REQ, WAIT), with the responder asserting DV in the cycle after the request.
- **Accept to o_done, counted in cycles after the accept edge:**
  - Byte: o_done in cycle 3.
  - Half: o_done in cycle 5.
  - Word: o_done in cycle 9.
- **Back-to-back:** a new i_req may be accepted in the cycle after DONE.
- **Busy:** o_busy=1 in REQ, WAIT and DONE.

## Configuration
- **Macro:** MEM_MASTER_ALIGN_CHECK_EN.
- **Defined:**
  - A half access at an odd address, or a word access with addr[1:0]≠0, issues no memory request.
  - The block goes IDLE→DONE with o_error=1 and o_rdata=0; o_done fires in cycle 1.
- **Undefined:** any alignment is performed bytewise and o_error is tied to 0.

## Structure
- **Package mem_master_pkg:**
  - Size encodings: SIZE_B, SIZE_H, SIZE_W.
  - State enum: IDLE, REQ, WAIT, DONE.
  - Byte-count function mapping size to N.
- **Sub-modules:** none; the block is a single module.

## Test plan
- **Word store:** store word 0xDEADBEEF at 0x10 → four requests to 0x10..0x13 with data EF, BE, AD, DE; o_done in cycle 9.
- **Word load:** load word from 0x10 → o_rdata=0xDEADBEEF.
- **Signed byte load:** load byte at 0x13 with i_unsigned=0 → 0xFFFFFFDE.
- **Unsigned byte load:** load byte at 0x13 with i_unsigned=1 → 0x000000DE.
- **Half store at 0x1FFF, macro undefined:** store half 0x1234 → requests to 0x1FFF (data 34) then 0x0000 (data 12).
- **Half store at 0x1FFF, macro defined:** same stimulus → no o_mem_request, o_error=1, o_done in cycle 1.
- **Busy and reset:** i_req pulsed while busy → ignored. Then i_rst_n=0 during byte 2 of a word load → all outputs 0 immediately, a stale DV is ignored, and the next byte load completes correctly.
- **DV stall:** DV delayed 3 cycles → the FSM waits in WAIT and latency grows by exactly 3.

Source files
------------

// File: rtl/mem_master_pkg.sv
// Shared types and helpers for the byte-wide memory request initiator.
package mem_master_pkg;

  // Access size encodings as presented by the load/store stage
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  // Number of byte transactions for an access size; the reserved code 11 behaves as a word
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_master_8to32.sv
// 32-bit load/store initiator that splits each access into 1, 2 or 4 sequential byte
// transactions, assembles little-endian read data and sign/zero-extends loads.
// Optional build macro MEM_MASTER_ALIGN_CHECK_EN: misaligned half/word accesses are rejected
// without touching memory and complete with o_error set.
module mem_master_8to32
  import mem_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_error,
  output logic                  o_mem_request,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [7:0]            o_mem_data,
  input  logic [7:0]            i_mem_data,
  input  logic                  i_mem_data_DV
);

  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            last_q, last_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic                  err_q, err_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            mdata_q, mdata_d;
  logic                  mwrite_q, mwrite_d;

  logic [2:0]            n_m1;
  logic                  misaligned;
  logic                  sign;
  logic [31:0]           load_final;

  // Upper address bits fall outside the memory window and wrap away
  logic unused_addr;
  assign unused_addr = ^i_addr[31:ADDR_WIDTH];

  assign n_m1 = byte_count(i_size) - 3'd1;

`ifdef MEM_MASTER_ALIGN_CHECK_EN
  assign misaligned = ((i_size == SIZE_H) && i_addr[0]) || (i_size[1] && (i_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Final load word: the byte arriving now is always the most significant one fetched
  always_comb begin
    sign = ~uns_q & i_mem_data[7];
    case (last_q)
      2'd0:    load_final = {{24{sign}}, i_mem_data};
      2'd1:    load_final = {{16{sign}}, i_mem_data, rdata_q[7:0]};
      default: load_final = {i_mem_data, rdata_q[23:0]};
    endcase
  end

  // Next-state logic: sequence the byte transactions and collect read data
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    we_d     = we_q;
    uns_d    = uns_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    mdata_d  = mdata_q;
    mwrite_d = mwrite_q;
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          uns_d   = i_unsigned;
          wdata_d = i_wdata;
          idx_d   = 2'd0;
          last_d  = n_m1[1:0];
          rdata_d = '0;
          err_d   = misaligned;
          if (misaligned) begin
            state_d = DONE;
          end else begin
            state_d  = REQ;
            addr_d   = i_addr[ADDR_WIDTH-1:0];
            mdata_d  = i_wdata[7:0];
            mwrite_d = i_we;
          end
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (i_mem_data_DV) begin
          if (!we_q) rdata_d[{idx_q, 3'b000} +: 8] = i_mem_data;
          if (idx_q == last_q) begin
            state_d = DONE;
            if (!we_q) rdata_d = load_final;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = REQ;
            addr_d  = addr_q + AddrOne;
            mdata_d = wdata_q[{idx_d, 3'b000} +: 8];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      last_q   <= 2'd0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      mdata_q  <= '0;
      mwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      we_q     <= we_d;
      uns_q    <= uns_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      mdata_q  <= mdata_d;
      mwrite_q <= mwrite_d;
    end
  end

  assign o_rdata       = rdata_q;
  assign o_done        = (state_q == DONE);
  assign o_busy        = (state_q != IDLE);
  assign o_error       = o_done & err_q;
  assign o_mem_request = (state_q == REQ);
  assign o_mem_write   = mwrite_q;
  assign o_mem_address = addr_q;
  assign o_mem_data    = mdata_q;

endmodule

// File: tb/tb_mem_master_8to32.sv
// Directed bench for mem_master_8to32 with a byte-wide memory responder model.
module tb_mem_master_8to32;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_done, o_busy, o_error;
  logic        o_mem_request, o_mem_write;
  logic [12:0] o_mem_address;
  logic [7:0]  o_mem_data;
  logic [7:0]  i_mem_data;
  logic        i_mem_data_DV;

  logic        resp_dv;
  logic        stale_dv;
  logic [7:0]  resp_data;
  int          stall;

  logic [7:0]  mem [0:8191];
  logic [12:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic        log_we[$];
  logic [12:0] ra;

  int n_checks = 0;
  int n_fail   = 0;

  assign i_mem_data_DV = resp_dv | stale_dv;
  assign i_mem_data    = resp_data;

  always #5 i_clk = ~i_clk;

  mem_master_8to32 #(.ADDR_WIDTH(13)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_rdata      (o_rdata),
    .o_done       (o_done),
    .o_busy       (o_busy),
    .o_error      (o_error),
    .o_mem_request(o_mem_request),
    .o_mem_write  (o_mem_write),
    .o_mem_address(o_mem_address),
    .o_mem_data   (o_mem_data),
    .i_mem_data   (i_mem_data),
    .i_mem_data_DV(i_mem_data_DV)
  );

  // Responder: acknowledges each request stall+1 edges later, one cycle wide
  initial begin
    resp_dv   = 1'b0;
    resp_data = 8'h00;
    forever begin
      @(posedge i_clk);
      #1;
      while (o_mem_request) begin
        ra = o_mem_address;
        log_addr.push_back(ra);
        log_data.push_back(o_mem_data);
        log_we.push_back(o_mem_write);
        if (o_mem_write) mem[ra] = o_mem_data;
        repeat (stall + 1) @(posedge i_clk);
        #1;
        resp_dv   = 1'b1;
        resp_data = mem[ra];
        @(posedge i_clk);
        #1;
        resp_dv = 1'b0;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_we.delete();
  endtask

  task automatic start_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge i_clk);
    #1;
    i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_wdata = wdata;
    i_req = 1'b1;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
  endtask

  // Returns the cycle (counted after the accept edge) in which o_done is seen
  task automatic wait_done(input int start, output int cyc, output logic [31:0] rd,
                           output logic err);
    cyc = start;
    while (o_done !== 1'b1 && cyc < 200) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    if (o_done !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: o_done=%b after %0d cycles, required 1", o_done, cyc);
    end
    rd  = o_rdata;
    err = o_error;
  endtask

  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int cyc, output logic [31:0] rd, output logic err);
    start_op(we, size, uns, addr, wdata);
    wait_done(1, cyc, rd, err);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_rdata, o_done, o_busy, o_error, o_mem_request, o_mem_write, o_mem_address,
         o_mem_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdata=%h done=%b busy=%b err=%b req=%b we=%b addr=%h data=%h, required all 0",
               o_rdata, o_done, o_busy, o_error, o_mem_request, o_mem_write, o_mem_address,
               o_mem_data);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_word_store();
    int cyc; logic [31:0] rd; logic err;
    logic [7:0] exp_d [4];
    exp_d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_log();
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, cyc, rd, err);
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL wstore_latency: %0d required 9", cyc); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL wstore_rdata: %h required 0", rd); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL wstore_error: %b required 0", err); end
    n_checks++;
    if (log_addr.size() != 4) begin
      n_fail++; $display("FAIL wstore_count: %0d requests required 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (log_addr[i] !== 13'(32'h10 + i) || log_data[i] !== exp_d[i] || log_we[i] !== 1'b1)
        begin
          n_fail++;
          $display("FAIL wstore_byte%0d: addr=%h data=%h we=%b required addr=%h data=%h we=1",
                   i, log_addr[i], log_data[i], log_we[i], 13'(32'h10 + i), exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_loads();
    int cyc; logic [31:0] rd; logic err;
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, cyc, rd, err);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wload_rdata: %h required deadbeef", rd); end
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL wload_latency: %0d required 9", cyc); end
    run_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, cyc, rd, err);
    n_checks++;
    if (rd !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL bload_signed: %h required ffffffde", rd); end
    n_checks++;
    if (cyc !== 3) begin n_fail++; $display("FAIL bload_latency: %0d required 3", cyc); end
    run_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, cyc, rd, err);
    n_checks++;
    if (rd !== 32'h000000DE) begin n_fail++; $display("FAIL bload_unsigned: %h required 000000de", rd); end
    run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, cyc, rd, err);
    n_checks++;
    if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL hload_signed: %h required ffffdead", rd); end
    n_checks++;
    if (cyc !== 5) begin n_fail++; $display("FAIL hload_latency: %0d required 5", cyc); end
  endtask

  task automatic test_half_wrap();
    int cyc; logic [31:0] rd; logic err;
    clear_log();
    run_op(1'b1, 2'b01, 1'b0, 32'h1FFF, 32'h00001234, cyc, rd, err);
`ifdef MEM_MASTER_ALIGN_CHECK_EN
    n_checks++;
    if (log_addr.size() != 0) begin n_fail++; $display("FAIL misalign_requests: %0d required 0", log_addr.size()); end
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_error: %b required 1", err); end
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL misalign_latency: %0d required 1", cyc); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL misalign_rdata: %h required 0", rd); end
`else
    n_checks++;
    if (log_addr.size() != 2) begin
      n_fail++; $display("FAIL wrap_count: %0d requests required 2", log_addr.size());
    end else begin
      n_checks++;
      if (log_addr[0] !== 13'h1FFF || log_data[0] !== 8'h34)
        begin n_fail++; $display("FAIL wrap_byte0: addr=%h data=%h required 1fff/34", log_addr[0], log_data[0]); end
      n_checks++;
      if (log_addr[1] !== 13'h0000 || log_data[1] !== 8'h12)
        begin n_fail++; $display("FAIL wrap_byte1: addr=%h data=%h required 0000/12", log_addr[1], log_data[1]); end
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL wrap_error: %b required 0", err); end
    n_checks++;
    if (cyc !== 5) begin n_fail++; $display("FAIL wrap_latency: %0d required 5", cyc); end
`endif
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] rd; logic err;
    run_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, cyc, rd, err);
    n_checks++;
    if (rd !== 32'h000000BE) begin n_fail++; $display("FAIL b2b_first: %h required 000000be", rd); end
    run_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, cyc, rd, err);
    n_checks++;
    if (rd !== 32'h0000BEEF || cyc !== 5)
      begin n_fail++; $display("FAIL b2b_second: rdata=%h cycles=%0d required 0000beef/5", rd, cyc); end
  endtask

  task automatic test_busy_reset();
    int cyc; logic [31:0] rd; logic err; int guard;
    clear_log();
    start_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    // Stray store request while busy must be ignored
    i_we = 1'b1; i_size = 2'b00; i_addr = 32'h0; i_wdata = 32'h55; i_req = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    wait_done(3, cyc, rd, err);
    n_checks++;
    if (rd !== 32'hDEADBEEF || cyc !== 9)
      begin n_fail++; $display("FAIL busy_ignore: rdata=%h cycles=%0d required deadbeef/9", rd, cyc); end
    n_checks++;
    if (log_addr.size() != 4 || log_we.sum() != 0)
      begin n_fail++; $display("FAIL busy_requests: %0d requests, writes=%0d required 4/0", log_addr.size(), log_we.sum()); end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after: busy=%b required 0", o_busy); end

    // Abort a word load while its second byte is outstanding
    clear_log();
    start_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    guard = 0;
    while (log_addr.size() < 2 && guard < 50) begin
      @(posedge i_clk); #1; guard++;
    end
    n_checks++;
    if (log_addr.size() < 2) begin n_fail++; $display("FAIL abort_reach: %0d requests required 2", log_addr.size()); end
    @(posedge i_clk); #2;
    i_rst_n  = 1'b0;
    stale_dv = 1'b1;
    #1;
    n_checks++;
    if ({o_rdata, o_done, o_busy, o_error, o_mem_request, o_mem_write, o_mem_address,
         o_mem_data} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: rdata=%h done=%b busy=%b req=%b addr=%h, required all 0",
               o_rdata, o_done, o_busy, o_mem_request, o_mem_address);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rdata !== 32'h0)
      begin n_fail++; $display("FAIL stale_dv: busy=%b done=%b rdata=%h required 0/0/0", o_busy, o_done, o_rdata); end
    stale_dv = 1'b0;
    run_op(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, cyc, rd, err);
    n_checks++;
    if (rd !== 32'h000000EF || cyc !== 3)
      begin n_fail++; $display("FAIL post_reset_load: rdata=%h cycles=%0d required 000000ef/3", rd, cyc); end
  endtask

  task automatic test_dv_stall();
    int cyc; logic [31:0] rd; logic err;
    stall = 3;
    run_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, cyc, rd, err);
    stall = 0;
    n_checks++;
    if (cyc !== 6) begin n_fail++; $display("FAIL stall_latency: %0d required 6", cyc); end
    n_checks++;
    if (rd !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL stall_rdata: %h required ffffffde", rd); end
  endtask

  initial begin
    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
    i_addr = 32'h0; i_wdata = 32'h0; stale_dv = 1'b0; stall = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    test_reset();
    test_word_store();
    test_loads();
    test_half_wrap();
    test_back_to_back();
    test_busy_reset();
    test_dv_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
